gpu_mem_arbiter: RTL

//  Shares one single-port frame memory between three requesters:
//   - host loader/readback (0)
//   - filter pixel fetch (1)
//   - filtered-pixel write-back (2)

---
 rtl/gpu_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 57 +++++
 rtl/gpu_mem_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// Shared constants and types for the GPU frame-memory arbiter slice.
package gpu_pkg;

  localparam int GPU_PIXEL_WIDTH = 8;
  localparam int GPU_ADDR_WIDTH  = 18;
  localparam int GPU_NUM_REQ     = 3;
  localparam int TAG_ID_W        = $clog2(GPU_NUM_REQ);

  localparam int REQ_HOST    = 0;
  localparam int REQ_FILT_RD = 1;
  localparam int REQ_FILT_WR = 2;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } mem_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first eligible index at or after the pointer wins,
// pointer moves just past the winner.
module rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] i_elig,
  output logic [NUM_REQ-1:0] o_gnt
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   ptr_r;
  logic [PTR_W-1:0]   ptr_nxt_s;
  logic [NUM_REQ-1:0] gnt_s;
  logic               found_s;

  // Rotating search over the eligible mask starting at the pointer
  always_comb begin : p_pick
    logic [PTR_W:0]   sum_v;
    logic [PTR_W-1:0] idx_v;
    gnt_s     = '0;
    found_s   = 1'b0;
    ptr_nxt_s = ptr_r;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum_v = {1'b0, ptr_r} + (PTR_W+1)'(i);
      if (sum_v >= (PTR_W+1)'(NUM_REQ)) begin
        sum_v = sum_v - (PTR_W+1)'(NUM_REQ);
      end else begin
        sum_v = sum_v;
      end
      idx_v = sum_v[PTR_W-1:0];
      if (!found_s && i_elig[idx_v]) begin
        gnt_s[idx_v] = 1'b1;
        found_s      = 1'b1;
        ptr_nxt_s    = (idx_v == PTR_W'(NUM_REQ - 1)) ? '0 : idx_v + PTR_W'(1);
      end else begin
        found_s = found_s;
      end
    end
  end

  assign o_gnt = gnt_s;

  // Pointer register, advanced only on a grant
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_r <= '0;
    end else if (found_s) begin
      ptr_r <= ptr_nxt_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/gpu_mem_arbiter.sv
// Shares one single-port frame memory between host, filter fetch and filter
// write-back; registers the winning command and steers read data back by tag.
module gpu_mem_arbiter
  import gpu_pkg::*;
#(
  parameter int PIXEL_WIDTH = GPU_PIXEL_WIDTH,
  parameter int ADDR_WIDTH  = GPU_ADDR_WIDTH,
  parameter int NUM_REQ     = GPU_NUM_REQ,
  parameter int RD_LATENCY  = 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_lock,
  input  logic [NUM_REQ-1:0]             i_req,
  input  logic [NUM_REQ-1:0]             i_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  i_addr,
  input  logic [NUM_REQ*PIXEL_WIDTH-1:0] i_wdata,
  output logic [NUM_REQ-1:0]             o_gnt,
  output logic [NUM_REQ-1:0]             o_rvalid,
  output logic [PIXEL_WIDTH-1:0]         o_rdata,
  output logic                           o_mem_en,
  output logic                           o_mem_we,
  output logic [ADDR_WIDTH-1:0]          o_mem_addr,
  output logic [PIXEL_WIDTH-1:0]         o_mem_wdata,
  input  logic [PIXEL_WIDTH-1:0]         i_mem_rdata,
  output logic                           o_busy
);

  if (NUM_REQ < 2 || NUM_REQ > (1 << TAG_ID_W)) begin : g_bad_num_req
    $error("gpu_mem_arbiter: NUM_REQ out of range");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_rd_latency
    $error("gpu_mem_arbiter: RD_LATENCY out of range");
  end

  // Tag written at grant, read out RD_LATENCY cycles after the command cycle
  localparam int DEPTH = 1 + RD_LATENCY;

  logic [NUM_REQ-1:0]     elig_s;
  logic [NUM_REQ-1:0]     gnt_s;
  logic [TAG_ID_W-1:0]    win_id_s;
  logic                   win_we_s;
  logic [ADDR_WIDTH-1:0]  win_addr_s;
  logic [PIXEL_WIDTH-1:0] win_wdata_s;
  logic                   mem_en_r;
  logic                   mem_we_r;
  logic [ADDR_WIDTH-1:0]  mem_addr_r;
  logic [PIXEL_WIDTH-1:0] mem_wdata_r;
  mem_tag_t               tag_r [DEPTH];
  logic [NUM_REQ-1:0]     rvalid_s;
  logic [PIXEL_WIDTH-1:0] rdata_s;
  logic                   busy_s;

  // Eligibility: nothing during reset, host only while locked
  always_comb begin
    elig_s = '0;
    if (i_rst) begin
      elig_s = '0;
    end else if (i_lock) begin
      elig_s = i_req & {{(NUM_REQ-1){1'b0}}, 1'b1};
    end else begin
      elig_s = i_req;
    end
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_elig (elig_s),
    .o_gnt  (gnt_s)
  );

  assign o_gnt = gnt_s;

  // Select the winner's command fields from the one-hot grant
  always_comb begin
    win_id_s    = '0;
    win_we_s    = 1'b0;
    win_addr_s  = '0;
    win_wdata_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_s[k]) begin
        win_id_s    = TAG_ID_W'(k);
        win_we_s    = i_we[k];
        win_addr_s  = i_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        win_wdata_s = i_wdata[k*PIXEL_WIDTH +: PIXEL_WIDTH];
      end else begin
        win_id_s = win_id_s;
      end
    end
  end

  // Command register and read-tag shift pipeline
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_r[i] <= '0;
      end
    end else begin
      mem_en_r <= |gnt_s;
      mem_we_r <= win_we_s;
      if (|gnt_s) begin
        mem_addr_r  <= win_addr_s;
        mem_wdata_r <= win_wdata_s;
      end else begin
        mem_addr_r  <= mem_addr_r;
        mem_wdata_r <= mem_wdata_r;
      end
      tag_r[0].valid <= (|gnt_s) & ~win_we_s;
      tag_r[0].id    <= win_id_s;
      for (int i = 1; i < DEPTH; i++) begin
        tag_r[i] <= tag_r[i-1];
      end
    end
  end

  // Steer returning read data to the requester named by the oldest tag
  always_comb begin
    rvalid_s = '0;
    rdata_s  = '0;
    busy_s   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_s = busy_s | tag_r[i].valid;
    end
    if (!i_rst && tag_r[DEPTH-1].valid) begin
      rvalid_s[tag_r[DEPTH-1].id] = 1'b1;
      rdata_s                     = i_mem_rdata;
    end else begin
      rvalid_s = '0;
      rdata_s  = '0;
    end
  end

  assign o_rvalid    = rvalid_s;
  assign o_rdata     = rdata_s;
  assign o_busy      = busy_s;
  assign o_mem_en    = mem_en_r;
  assign o_mem_we    = mem_we_r;
  assign o_mem_addr  = mem_addr_r;
  assign o_mem_wdata = mem_wdata_r;

endmodule
